// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control path.
// Contents: FSM state enum, opcode / funct / rs constants, mux select
// encodings for pcsrc, regdst, memtoreg and aluop, and the instruction
// class enum produced by mips_op_decode.
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_COP0  = 6'b010000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_JALR  = 6'b001001;

  localparam logic [4:0] RS_MFC0  = 5'b00000;
  localparam logic [4:0] RS_MTC0  = 5'b00100;

  localparam logic [1:0] PCSRC_PC4    = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_RS     = 2'b11;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] MTR_ALU  = 2'b00;
  localparam logic [1:0] MTR_MEM  = 2'b01;
  localparam logic [1:0] MTR_LINK = 2'b10;
  localparam logic [1:0] MTR_CP0  = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;

  typedef enum logic [3:0] {
    C_RTYPE, C_IMM, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JR,
    C_JAL, C_JALR, C_MFC0, C_MTC0, C_ILLEGAL
  } iclass_e;

endpackage

// File: rtl/mips_op_decode.sv
// Combinational instruction classifier.
// Ports:
//   op_i      IR[31:26]
//   funct_i   IR[5:0]   (selects jr / jalr under op 000000)
//   rs_i      IR[25:21] (selects mfc0 / mtc0 under op 010000)
//   cls_o     instruction class
//   illegal_o high when the instruction cannot be decoded
module mips_op_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  input  logic [4:0] rs_i,
  output iclass_e    cls_o,
  output logic       illegal_o
);

  always_comb begin
    cls_o = C_ILLEGAL;
    case (op_i)
      OP_RTYPE: begin
        // Every funct other than the two register jumps is an ALU op.
        if (funct_i == FN_JR)        cls_o = C_JR;
        else if (funct_i == FN_JALR) cls_o = C_JALR;
        else                         cls_o = C_RTYPE;
      end
      OP_J:    cls_o = C_J;
      OP_JAL:  cls_o = C_JAL;
      OP_BEQ:  cls_o = C_BEQ;
      OP_BNE:  cls_o = C_BNE;
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: cls_o = C_IMM;
      OP_LW:   cls_o = C_LW;
      OP_SW:   cls_o = C_SW;
      OP_COP0: begin
        if (rs_i == RS_MFC0)      cls_o = C_MFC0;
        else if (rs_i == RS_MTC0) cls_o = C_MTC0;
        else                      cls_o = C_ILLEGAL;
      end
      default: cls_o = C_ILLEGAL;
    endcase
  end

  assign illegal_o = (cls_o == C_ILLEGAL);

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM (IF, ID, EX, MEM, WB).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   op, funct, rs       instruction fields, valid from ID onward
//   zero                ALU zero flag, used by branches in EX
//   imem_ready          instruction memory data available
//   dmem_ready          data memory access completes
//   imem_read, irwrite, pcwrite, pcsrc, regdst, alusrc, aluop,
//   memtoreg, regwrite, dmem_read, dmem_write, cp0_write
//                       datapath requests, strobes and mux selects
//   instr_done          pulse in the final cycle of each instruction
//   illegal_op          pulse in ID for an undecodable instruction
//
// Handshake: imem_read (IF) and dmem_read/dmem_write (MEM) are requests
// that stay high and unchanged until the matching ready is sampled high
// in that same state; the transfer happens in the cycle where request and
// ready are both high. A ready seen in any other state, or while rst is
// high, has no effect.
module mips_mc_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic [4:0] rs,
  input  logic       zero,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_read,
  output logic       irwrite,
  output logic       pcwrite,
  output logic [1:0] pcsrc,
  output logic [1:0] regdst,
  output logic       alusrc,
  output logic [1:0] aluop,
  output logic [1:0] memtoreg,
  output logic       regwrite,
  output logic       dmem_read,
  output logic       dmem_write,
  output logic       cp0_write,
  output logic       instr_done,
  output logic       illegal_op
);

  state_e  state_q, state_d;
  iclass_e cls_q, cls_d;
  iclass_e dec_cls;
  logic    dec_illegal;

  mips_op_decode u_decode (
    .op_i      (op),
    .funct_i   (funct),
    .rs_i      (rs),
    .cls_o     (dec_cls),
    .illegal_o (dec_illegal)
  );

  // Outputs depend on the live ready/zero inputs, so they are decoded
  // combinationally from the state and class rather than registered.
  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    imem_read  = 1'b0;
    irwrite    = 1'b0;
    pcwrite    = 1'b0;
    pcsrc      = PCSRC_PC4;
    regdst     = REGDST_RT;
    alusrc     = 1'b0;
    aluop      = ALUOP_ADD;
    memtoreg   = MTR_ALU;
    regwrite   = 1'b0;
    dmem_read  = 1'b0;
    dmem_write = 1'b0;
    cp0_write  = 1'b0;
    instr_done = 1'b0;
    illegal_op = 1'b0;

    case (state_q)
      S_IF: begin
        imem_read = 1'b1;
        if (imem_ready) begin
          irwrite = 1'b1;
          pcwrite = 1'b1;
          pcsrc   = PCSRC_PC4;
          state_d = S_ID;
        end
      end

      S_ID: begin
        // Later states use the registered class, so the IR fields only
        // need to be stable during this cycle.
        cls_d   = dec_cls;
        state_d = S_EX;
        if (dec_illegal) begin
          illegal_op = 1'b1;
          instr_done = 1'b1;
          state_d    = S_IF;
        end else begin
          case (dec_cls)
            C_J:    begin pcwrite = 1'b1; pcsrc = PCSRC_JUMP; instr_done = 1'b1; state_d = S_IF; end
            C_JR:   begin pcwrite = 1'b1; pcsrc = PCSRC_RS;   instr_done = 1'b1; state_d = S_IF; end
            C_JAL:  begin pcwrite = 1'b1; pcsrc = PCSRC_JUMP; state_d = S_WB; end
            C_JALR: begin pcwrite = 1'b1; pcsrc = PCSRC_RS;   state_d = S_WB; end
            C_MFC0: state_d = S_WB;
            default: state_d = S_EX;
          endcase
        end
      end

      S_EX: begin
        state_d = S_IF;
        case (cls_q)
          C_RTYPE: begin aluop = ALUOP_FUNCT; state_d = S_WB; end
          C_IMM:   begin alusrc = 1'b1; aluop = ALUOP_IMM; state_d = S_WB; end
          C_LW, C_SW: begin alusrc = 1'b1; aluop = ALUOP_ADD; state_d = S_MEM; end
          C_BEQ, C_BNE: begin
            aluop = ALUOP_SUB;
            // beq is taken on zero==1, bne on zero==0.
            if ((cls_q == C_BEQ) == zero) begin
              pcwrite = 1'b1;
              pcsrc   = PCSRC_BRANCH;
            end
            instr_done = 1'b1;
          end
          C_MTC0:  begin cp0_write = 1'b1; instr_done = 1'b1; end
          default: state_d = S_IF;
        endcase
      end

      S_MEM: begin
        dmem_read  = (cls_q == C_LW);
        dmem_write = (cls_q == C_SW);
        if (dmem_ready) begin
          if (cls_q == C_LW) begin
            state_d = S_WB;
          end else begin
            instr_done = 1'b1;
            state_d    = S_IF;
          end
        end
      end

      S_WB: begin
        regwrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_IF;
        case (cls_q)
          C_RTYPE: begin regdst = REGDST_RD; memtoreg = MTR_ALU;  end
          C_IMM:   begin regdst = REGDST_RT; memtoreg = MTR_ALU;  end
          C_LW:    begin regdst = REGDST_RT; memtoreg = MTR_MEM;  end
          C_JAL:   begin regdst = REGDST_RA; memtoreg = MTR_LINK; end
          C_JALR:  begin regdst = REGDST_RD; memtoreg = MTR_LINK; end
          C_MFC0:  begin regdst = REGDST_RT; memtoreg = MTR_CP0;  end
          default: begin regdst = REGDST_RT; memtoreg = MTR_ALU;  end
        endcase
      end

      default: state_d = S_IF;
    endcase

    // Reset silences every output and ignores both readies, which also
    // abandons any in-flight memory access.
    if (rst) begin
      state_d    = S_IF;
      imem_read  = 1'b0;
      irwrite    = 1'b0;
      pcwrite    = 1'b0;
      pcsrc      = PCSRC_PC4;
      regdst     = REGDST_RT;
      alusrc     = 1'b0;
      aluop      = ALUOP_ADD;
      memtoreg   = MTR_ALU;
      regwrite   = 1'b0;
      dmem_read  = 1'b0;
      dmem_write = 1'b0;
      cp0_write  = 1'b0;
      instr_done = 1'b0;
      illegal_op = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IF;
      cls_q   <= C_ILLEGAL;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
    end
  end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Self-checking bench for mips_mc_ctrl. A reference model expands each
// instruction into its expected per-cycle output trace from the class
// latency rules, then the trace is replayed against the DUT.
module tb_mips_mc_ctrl;

  typedef struct packed {
    logic       imem_read;
    logic       irwrite;
    logic       pcwrite;
    logic [1:0] pcsrc;
    logic [1:0] regdst;
    logic       alusrc;
    logic [1:0] aluop;
    logic [1:0] memtoreg;
    logic       regwrite;
    logic       dmem_read;
    logic       dmem_write;
    logic       cp0_write;
    logic       instr_done;
    logic       illegal_op;
  } out_t;

  typedef struct packed {
    logic rst_f;
    logic imr;
    logic dmr;
    logic z;
    logic real_f;
  } stim_t;

  localparam int OUT_W = $bits(out_t);

  typedef enum int {
    K_R, K_IMM, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JR,
    K_JAL, K_JALR, K_MFC0, K_MTC0, K_ILL
  } kind_e;

  // ---------------- clock / reset / DUT ----------------
  logic       clk;
  logic       rst;
  logic [5:0] op, funct;
  logic [4:0] rs;
  logic       zero, imem_ready, dmem_ready;
  logic       imem_read, irwrite, pcwrite, alusrc, regwrite;
  logic [1:0] pcsrc, regdst, aluop, memtoreg;
  logic       dmem_read, dmem_write, cp0_write, instr_done, illegal_op;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mips_mc_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .funct      (funct),
    .rs         (rs),
    .zero       (zero),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .imem_read  (imem_read),
    .irwrite    (irwrite),
    .pcwrite    (pcwrite),
    .pcsrc      (pcsrc),
    .regdst     (regdst),
    .alusrc     (alusrc),
    .aluop      (aluop),
    .memtoreg   (memtoreg),
    .regwrite   (regwrite),
    .dmem_read  (dmem_read),
    .dmem_write (dmem_write),
    .cp0_write  (cp0_write),
    .instr_done (instr_done),
    .illegal_op (illegal_op)
  );

  // ---------------- scoreboard ----------------
  logic [OUT_W-1:0] exp_q[$];
  stim_t            stim_q[$];
  int               n_checks;
  int               n_errors;
  int               instr_no;
  logic [5:0]       cur_op, cur_funct;
  logic [4:0]       cur_rs;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic out_t observed();
    out_t o;
    o.imem_read  = imem_read;
    o.irwrite    = irwrite;
    o.pcwrite    = pcwrite;
    o.pcsrc      = pcsrc;
    o.regdst     = regdst;
    o.alusrc     = alusrc;
    o.aluop      = aluop;
    o.memtoreg   = memtoreg;
    o.regwrite   = regwrite;
    o.dmem_read  = dmem_read;
    o.dmem_write = dmem_write;
    o.cp0_write  = cp0_write;
    o.instr_done = instr_done;
    o.illegal_op = illegal_op;
    return o;
  endfunction

  // ---------------- reference model ----------------
  function automatic kind_e classify(input logic [5:0] o, input logic [5:0] f, input logic [4:0] r);
    kind_e k;
    k = K_ILL;
    case (o)
      6'd0: begin
        if (f == 6'h08)      k = K_JR;
        else if (f == 6'h09) k = K_JALR;
        else                 k = K_R;
      end
      6'd2:  k = K_J;
      6'd3:  k = K_JAL;
      6'd4:  k = K_BEQ;
      6'd5:  k = K_BNE;
      6'd8, 6'd10, 6'd12, 6'd13, 6'd15: k = K_IMM;
      6'd35: k = K_LW;
      6'd43: k = K_SW;
      6'd16: begin
        if (r == 5'd0)      k = K_MFC0;
        else if (r == 5'd4) k = K_MTC0;
        else                k = K_ILL;
      end
      default: k = K_ILL;
    endcase
    return k;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input out_t e, input logic rst_f, input logic imr,
                      input logic dmr, input logic z, input logic real_f);
    stim_t s;
    s.rst_f  = rst_f;
    s.imr    = imr;
    s.dmr    = dmr;
    s.z      = z;
    s.real_f = real_f;
    exp_q.push_back(e);
    stim_q.push_back(s);
  endtask

  // Builds the expected cycle trace of one instruction. iw / dw are the
  // number of not-ready cycles in fetch / memory; rst_at, when within the
  // trace, replaces that cycle and everything after it with one reset cycle.
  task automatic plan(input logic [5:0] o, input logic [5:0] f, input logic [4:0] r,
                      input int iw, input int dw, input logic z, input int rst_at);
    kind_e k;
    out_t  e;
    k = classify(o, f, r);

    for (int w = 0; w < iw; w++) begin
      e = '0; e.imem_read = 1'b1;
      push(e, 1'b0, 1'b0, rb(), rb(), 1'b0);
    end
    e = '0; e.imem_read = 1'b1; e.irwrite = 1'b1; e.pcwrite = 1'b1; e.pcsrc = 2'b00;
    push(e, 1'b0, 1'b1, rb(), rb(), 1'b0);

    e = '0;
    case (k)
      K_J:    begin e.pcwrite = 1'b1; e.pcsrc = 2'b10; e.instr_done = 1'b1; end
      K_JR:   begin e.pcwrite = 1'b1; e.pcsrc = 2'b11; e.instr_done = 1'b1; end
      K_JAL:  begin e.pcwrite = 1'b1; e.pcsrc = 2'b10; end
      K_JALR: begin e.pcwrite = 1'b1; e.pcsrc = 2'b11; end
      K_ILL:  begin e.illegal_op = 1'b1; e.instr_done = 1'b1; end
      default: ;
    endcase
    push(e, 1'b0, rb(), rb(), rb(), 1'b1);

    if (k inside {K_R, K_IMM, K_LW, K_SW, K_BEQ, K_BNE, K_MTC0}) begin
      e = '0;
      case (k)
        K_R:   e.aluop = 2'b10;
        K_IMM: begin e.alusrc = 1'b1; e.aluop = 2'b11; end
        K_LW, K_SW: begin e.alusrc = 1'b1; e.aluop = 2'b00; end
        K_BEQ, K_BNE: begin
          e.aluop = 2'b01;
          e.instr_done = 1'b1;
          if ((k == K_BEQ && z) || (k == K_BNE && !z)) begin
            e.pcwrite = 1'b1; e.pcsrc = 2'b01;
          end
        end
        K_MTC0: begin e.cp0_write = 1'b1; e.instr_done = 1'b1; end
        default: ;
      endcase
      push(e, 1'b0, rb(), rb(), z, 1'b0);
    end

    if (k == K_LW || k == K_SW) begin
      for (int w = 0; w < dw; w++) begin
        e = '0; e.dmem_read = (k == K_LW); e.dmem_write = (k == K_SW);
        push(e, 1'b0, rb(), 1'b0, rb(), 1'b0);
      end
      e = '0; e.dmem_read = (k == K_LW); e.dmem_write = (k == K_SW);
      e.instr_done = (k == K_SW);
      push(e, 1'b0, rb(), 1'b1, rb(), 1'b0);
    end

    if (k inside {K_R, K_IMM, K_LW, K_JAL, K_JALR, K_MFC0}) begin
      e = '0; e.regwrite = 1'b1; e.instr_done = 1'b1;
      case (k)
        K_R:    begin e.regdst = 2'b01; e.memtoreg = 2'b00; end
        K_IMM:  begin e.regdst = 2'b00; e.memtoreg = 2'b00; end
        K_LW:   begin e.regdst = 2'b00; e.memtoreg = 2'b01; end
        K_JAL:  begin e.regdst = 2'b10; e.memtoreg = 2'b10; end
        K_JALR: begin e.regdst = 2'b01; e.memtoreg = 2'b10; end
        default: begin e.regdst = 2'b00; e.memtoreg = 2'b11; end
      endcase
      push(e, 1'b0, rb(), rb(), rb(), 1'b0);
    end

    if (rst_at >= 0 && rst_at < exp_q.size()) begin
      while (exp_q.size() > rst_at) begin
        void'(exp_q.pop_back());
        void'(stim_q.pop_back());
      end
      // Both readies high during reset: they must be ignored.
      push('0, 1'b1, 1'b1, 1'b1, rb(), 1'b0);
    end
  endtask

  // ---------------- driver ----------------
  // Entered at posedge+1; drives one cycle, checks at the negedge.
  task automatic run();
    int   step;
    out_t e;
    stim_t s;
    logic [31:0] g, x;
    step = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      s = stim_q.pop_front();
      rst        = s.rst_f;
      imem_ready = s.imr;
      dmem_ready = s.dmr;
      zero       = s.z;
      if (s.real_f) begin
        op = cur_op; funct = cur_funct; rs = cur_rs;
      end else begin
        op = 6'($urandom); funct = 6'($urandom); rs = 5'($urandom);
      end
      @(negedge clk);
      g = '0; g[OUT_W-1:0] = observed();
      x = '0; x[OUT_W-1:0] = e;
      check($sformatf("instr%0d_op%0h_cyc%0d", instr_no, cur_op, step), g, x);
      @(posedge clk);
      #1;
      step++;
    end
  endtask

  task automatic do_instr(input logic [5:0] o, input logic [5:0] f, input logic [4:0] r,
                          input int iw, input int dw, input logic z, input int rst_at);
    cur_op = o; cur_funct = f; cur_rs = r;
    plan(o, f, r, iw, dw, z, rst_at);
    run();
    instr_no++;
  endtask

  // ---------------- stimulus ----------------
  logic [5:0] op_tab [0:15] = '{6'd0, 6'd0, 6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd8,
                                6'd10, 6'd12, 6'd13, 6'd15, 6'd16, 6'd16, 6'd35, 6'd43};

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] g;
    logic [5:0]  o, f;
    logic [4:0]  r;
    int          rst_at;
    n_checks = 0; n_errors = 0; instr_no = 0;
    rst = 1'b1; op = '0; funct = '0; rs = '0; zero = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0;

    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      imem_ready = rb(); dmem_ready = rb();
      @(negedge clk);
      g = '0; g[OUT_W-1:0] = observed();
      check($sformatf("reset_cyc%0d", i), g, 32'd0);
      @(posedge clk);
      #1;
    end

    // Directed cases.
    do_instr(6'd0,  6'h20, 5'd1,  0, 0, 1'b0, -1);  // add
    do_instr(6'd35, 6'h11, 5'd2,  0, 2, 1'b0, -1);  // lw, 2 memory waits
    do_instr(6'd4,  6'h00, 5'd3,  0, 0, 1'b1, -1);  // beq taken
    do_instr(6'd4,  6'h00, 5'd3,  0, 0, 1'b0, -1);  // beq not taken
    do_instr(6'd5,  6'h00, 5'd3,  0, 0, 1'b0, -1);  // bne taken
    do_instr(6'd5,  6'h00, 5'd3,  1, 0, 1'b1, -1);  // bne not taken
    do_instr(6'd3,  6'h00, 5'd0,  0, 0, 1'b0, -1);  // jal
    do_instr(6'h3f, 6'h00, 5'd0,  0, 0, 1'b0, -1);  // illegal opcode
    do_instr(6'd43, 6'h00, 5'd0,  1, 3, 1'b0, 4);   // sw, reset in MEM wait
    do_instr(6'd2,  6'h00, 5'd0,  2, 0, 1'b0, -1);  // j with fetch waits
    do_instr(6'd0,  6'h08, 5'd7,  0, 0, 1'b0, -1);  // jr
    do_instr(6'd0,  6'h09, 5'd7,  0, 0, 1'b0, -1);  // jalr
    do_instr(6'd16, 6'h00, 5'd0,  0, 0, 1'b0, -1);  // mfc0
    do_instr(6'd16, 6'h00, 5'd4,  0, 0, 1'b0, -1);  // mtc0
    do_instr(6'd16, 6'h00, 5'd9,  0, 0, 1'b0, -1);  // cop0, undefined rs
    do_instr(6'd15, 6'h00, 5'd0,  0, 0, 1'b0, -1);  // lui
    do_instr(6'd43, 6'h00, 5'd0,  0, 0, 1'b0, -1);  // sw, no waits

    // Randomized instruction stream.
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 7) == 0) o = 6'($urandom);
      else                           o = op_tab[$urandom_range(0, 15)];
      case ($urandom_range(0, 3))
        0:       f = 6'h08;
        1:       f = 6'h09;
        default: f = 6'($urandom);
      endcase
      case ($urandom_range(0, 2))
        0:       r = 5'd0;
        1:       r = 5'd4;
        default: r = 5'($urandom);
      endcase
      rst_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 6)) : -1;
      do_instr(o, f, r, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), rb(), rst_at);
    end

    rst = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
